// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and defaults for the memory bus arbiter
//
// Purpose: FSM state enum, bus owner encoding, default bus widths and a
// counter-width helper used by mem_bus_arbiter and mem_arb_pick.
// Ports: none (package).

package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IBUS = 1'b0,
    OWN_DBUS = 1'b1
  } owner_t;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select and starvation counter update
//
// Purpose: combinational arbitration between instruction and data bus.
// Data bus wins a contested cycle unless the instruction bus has already
// lost STARVE_MAX times in a row, in which case the instruction bus wins.
// Ports:
//   ibus_req     in   instruction bus request
//   dbus_req     in   data bus request
//   starve_cnt   in   consecutive contested dbus wins so far
//   pick_valid   out  at least one request present
//   pick_ibus    out  1 = instruction bus wins, 0 = data bus wins
//   starve_next  out  counter value to store if this pick is taken

module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
  input  logic             ibus_req,
  input  logic             dbus_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             pick_valid,
  output logic             pick_ibus,
  output logic [CNT_W-1:0] starve_next
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic starved;

  always_comb begin
    starved     = (starve_cnt == STARVE_LIM);
    pick_valid  = ibus_req | dbus_req;
    pick_ibus   = ibus_req & (~dbus_req | starved);
    starve_next = starve_cnt;
    if (pick_ibus) begin
      starve_next = '0;
    end else if (dbus_req && ibus_req && !starved) begin
      // Only a dbus win over a waiting ibus counts; saturates at the limit.
      starve_next = starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - one-outstanding arbiter of ibus/dbus onto a memory port
//
// Purpose: shares a single memory port between the instruction and data
// buses. One transaction in flight; data bus priority with bounded
// instruction-fetch starvation; response timeout returns an error.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ibus_req_i/addr_i              fetch request, held until ibus_gnt_o
//   ibus_gnt_o/rvalid_o/rdata_o/err_o  fetch accept, response, data, timeout
//   dbus_req_i/we_i/addr_i/wdata_i/sel_i  data request, held until dbus_gnt_o
//   dbus_gnt_o/rvalid_o/rdata_o/err_o  data accept, response/ack, data, timeout
//   mem_req_o/we_o/addr_o/wdata_o/sel_o  memory request and registered fields
//   mem_gnt_i/rvalid_i/rdata_i     memory accept, response, read data
//   busy_o                         a transaction is in progress

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ibus_req_i,
  input  logic [ADDR_W-1:0]   ibus_addr_i,
  output logic                ibus_gnt_o,
  output logic                ibus_rvalid_o,
  output logic [DATA_W-1:0]   ibus_rdata_o,
  output logic                ibus_err_o,
  input  logic                dbus_req_i,
  input  logic                dbus_we_i,
  input  logic [ADDR_W-1:0]   dbus_addr_i,
  input  logic [DATA_W-1:0]   dbus_wdata_i,
  input  logic [DATA_W/8-1:0] dbus_sel_i,
  output logic                dbus_gnt_o,
  output logic                dbus_rvalid_o,
  output logic [DATA_W-1:0]   dbus_rdata_o,
  output logic                dbus_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int SEL_W  = DATA_W / 8;
  localparam int SCNT_W = cnt_width(STARVE_MAX);
  localparam int TCNT_W = cnt_width(TIMEOUT);
  localparam logic [TCNT_W-1:0] TIMEOUT_LIM = TCNT_W'(TIMEOUT);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [SCNT_W-1:0]   starve_q, starve_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                load;

  logic                pick_valid;
  logic                pick_ibus;
  logic [SCNT_W-1:0]   starve_next;

  logic                grant;
  logic                resp_ok;
  logic                resp_err;
  logic                own_i;
  logic                own_d;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (SCNT_W)
  ) u_pick (
    .ibus_req    (ibus_req_i),
    .dbus_req    (dbus_req_i),
    .starve_cnt  (starve_q),
    .pick_valid  (pick_valid),
    .pick_ibus   (pick_ibus),
    .starve_next (starve_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_DBUS;
      starve_q <= '0;
      tcnt_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      tcnt_q   <= tcnt_d;
      if (load) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        sel_q   <= sel_d;
      end
    end
  end

  // Next-state and handshake decode. mem_rvalid_i is only looked at in
  // WAIT_RESP, so stray or late responses elsewhere are dropped.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    tcnt_d   = tcnt_q;
    load     = 1'b0;
    grant    = 1'b0;
    resp_ok  = 1'b0;
    resp_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          load     = 1'b1;
          owner_d  = pick_ibus ? OWN_IBUS : OWN_DBUS;
          starve_d = starve_next;
          state_d  = REQ;
        end
      end
      REQ: begin
        grant = mem_gnt_i;
        if (mem_gnt_i) begin
          tcnt_d  = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid_i) begin
          resp_ok = 1'b1;
          state_d = IDLE;
        end else if (tcnt_q == TIMEOUT_LIM) begin
          resp_err = 1'b1;
          state_d  = IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fields for the winning request; a fetch is a full-width read.
  always_comb begin
    if (pick_ibus) begin
      we_d    = 1'b0;
      addr_d  = ibus_addr_i;
      wdata_d = '0;
      sel_d   = '1;
    end else begin
      we_d    = dbus_we_i;
      addr_d  = dbus_addr_i;
      wdata_d = dbus_wdata_i;
      sel_d   = dbus_sel_i;
    end
  end

  assign own_i = (owner_q == OWN_IBUS);
  assign own_d = (owner_q == OWN_DBUS);

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_sel_o   = sel_q;
  assign busy_o      = (state_q != IDLE);

  assign ibus_gnt_o    = grant & own_i;
  assign ibus_rvalid_o = (resp_ok | resp_err) & own_i;
  assign ibus_err_o    = resp_err & own_i;
  assign ibus_rdata_o  = (resp_ok & own_i) ? mem_rdata_i : '0;

  assign dbus_gnt_o    = grant & own_d;
  assign dbus_rvalid_o = (resp_ok | resp_err) & own_d;
  assign dbus_err_o    = resp_err & own_d;
  assign dbus_rdata_o  = (resp_ok & own_d) ? mem_rdata_i : '0;

endmodule
